// File: rtl/bram_stream_reader.sv
// Read-side client for a dual-ported block RAM staging buffer: turns an (address, length)
// command into RAM reads and delivers the words as a valid/ready stream with a last flag.
module bram_stream_reader #(
  parameter int AW = 10,
  parameter int DW = 36,
  parameter int LW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_issue_left;
  logic          r_inflight;
  logic          r_inflight_last;

  // Two-entry output FIFO: the head entry drives the stream outputs directly.
  logic          r_head_valid;
  logic          r_head_last;
  logic [DW-1:0] r_head_data;
  logic          r_tail_valid;
  logic          r_tail_last;
  logic [DW-1:0] r_tail_data;

  logic          w_pop;
  logic [1:0]    w_occ;
  logic [1:0]    w_pending;
  logic          w_issue;

  assign w_pop     = r_head_valid & out_ready;
  assign w_occ     = {1'b0, r_head_valid} + {1'b0, r_tail_valid};
  assign w_pending = w_occ + {1'b0, r_inflight};

  // Issue only when the read about to land is guaranteed a FIFO slot.
  assign w_issue = (r_state == S_RUN) && (r_issue_left != '0) &&
                   ((w_pending < 2'd2) || w_pop);

  assign cmd_ready = (r_state == S_IDLE);
  assign ram_en    = w_issue;
  assign ram_addr  = r_addr;
  assign out_valid = r_head_valid;
  assign out_data  = r_head_data;
  assign out_last  = r_head_last;
  assign done      = (r_state == S_ZERO) ||
                     ((r_state == S_RUN) && w_pop && r_head_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_issue_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_head_valid    <= 1'b0;
      r_head_last     <= 1'b0;
      r_head_data     <= '0;
      r_tail_valid    <= 1'b0;
      r_tail_last     <= 1'b0;
      r_tail_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr       <= cmd_addr;
            r_issue_left <= cmd_len;
            r_state      <= (cmd_len == '0) ? S_ZERO : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop && r_head_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_issue_left == LW'(1));
      if (w_issue) begin
        r_addr       <= r_addr + AW'(1);
        r_issue_left <= r_issue_left - LW'(1);
      end

      // A pop and a capture in the same clock keep occupancy and order intact.
      if (w_pop) begin
        if (r_tail_valid) begin
          r_head_data  <= r_tail_data;
          r_head_last  <= r_tail_last;
          r_tail_valid <= r_inflight;
          if (r_inflight) begin
            r_tail_data <= ram_rd;
            r_tail_last <= r_inflight_last;
          end
        end else begin
          r_head_valid <= r_inflight;
          r_head_last  <= r_inflight ? r_inflight_last : 1'b0;
          if (r_inflight) begin
            r_head_data <= ram_rd;
          end
        end
      end else if (r_inflight) begin
        if (r_head_valid) begin
          r_tail_valid <= 1'b1;
          r_tail_data  <= ram_rd;
          r_tail_last  <= r_inflight_last;
        end else begin
          r_head_valid <= 1'b1;
          r_head_data  <= ram_rd;
          r_head_last  <= r_inflight_last;
        end
      end
    end
  end

endmodule
